// File: rtl/clock_route_enable_sequencer.sv
// clock_route_enable_sequencer
// Control-domain sequencer for the async enable handshake of the clock-route
// sync stage. It raises async_enable on request, synchronises the returning
// ack, waits for the ack to settle before reporting the route active, and
// records timeouts or ack loss as a sticky error.
//
// Ports:
//   clock            - sole clock, rising edge
//   async_reset      - asynchronous active-high reset
//   route_req        - level request: 1 = route clock, 0 = release
//   error_clear      - pulse that clears the sticky error (only while ack_s=0)
//   async_enable     - enable request to the downstream sync stage
//   async_enable_ack - ack from the downstream stage (asynchronous)
//   route_active     - route established and stable
//   route_busy       - sequencer in REQ, SETTLE or DRAIN
//   route_error      - sticky error flag
//   error_code       - 0 none, 1 request timeout, 2 drain timeout, 3 ack lost
module clock_route_enable_sequencer #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 200,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       clock,
    input  logic       async_reset,
    input  logic       route_req,
    input  logic       error_clear,
    output logic       async_enable,
    input  logic       async_enable_ack,
    output logic       route_active,
    output logic       route_busy,
    output logic       route_error,
    output logic [1:0] error_code
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_SETTLE = 3'd2,
        S_ACTIVE = 3'd3,
        S_DRAIN  = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_REQ_TMO   = 2'd1;
    localparam logic [1:0] ERR_DRAIN_TMO = 2'd2;
    localparam logic [1:0] ERR_ACK_LOST  = 2'd3;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ack_s;
    logic [1:0]             err_cause;

    logic       async_enable_q, async_enable_d;
    logic       route_active_q, route_active_d;
    logic       route_busy_q, route_busy_d;
    logic       route_error_q, route_error_d;
    logic [1:0] error_code_q, error_code_d;

    // Ack synchroniser: raw ack enters bit 0, ack_s is the last stage.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_enable_ack};
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

    // State, counter, synchroniser and output registers.
    always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            sync_q         <= '0;
            async_enable_q <= 1'b0;
            route_active_q <= 1'b0;
            route_busy_q   <= 1'b0;
            route_error_q  <= 1'b0;
            error_code_q   <= ERR_NONE;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sync_q         <= sync_d;
            async_enable_q <= async_enable_d;
            route_active_q <= route_active_d;
            route_busy_q   <= route_busy_d;
            route_error_q  <= route_error_d;
            error_code_q   <= error_code_d;
        end
    end

    // Next state, error cause and shared counter.
    always_comb begin
        state_d   = state_q;
        err_cause = ERR_NONE;
        unique case (state_q)
            S_IDLE: begin
                if (route_req) state_d = S_REQ;
            end
            S_REQ: begin
                if (!route_req) begin
                    state_d = S_DRAIN;
                end else if (ack_s) begin
                    state_d = S_SETTLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = S_ERROR;
                    err_cause = ERR_REQ_TMO;
                end
            end
            S_SETTLE: begin
                if (!route_req) begin
                    state_d = S_DRAIN;
                end else if (!ack_s) begin
                    state_d   = S_ERROR;
                    err_cause = ERR_ACK_LOST;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (!route_req) begin
                    state_d = S_DRAIN;
                end else if (!ack_s) begin
                    state_d   = S_ERROR;
                    err_cause = ERR_ACK_LOST;
                end
            end
            S_DRAIN: begin
                if (!ack_s) begin
                    state_d = S_IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = S_ERROR;
                    err_cause = ERR_DRAIN_TMO;
                end
            end
            S_ERROR: begin
                // A clear while the ack is still high is dropped, not deferred.
                if (error_clear && !ack_s) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Output decode from next state so the registered outputs track state_q.
    always_comb begin
        async_enable_d = 1'b0;
        route_active_d = 1'b0;
        route_busy_d   = 1'b0;
        route_error_d  = 1'b0;
        error_code_d   = ERR_NONE;
        unique case (state_d)
            S_REQ, S_SETTLE: begin
                async_enable_d = 1'b1;
                route_busy_d   = 1'b1;
            end
            S_ACTIVE: begin
                async_enable_d = 1'b1;
                route_active_d = 1'b1;
            end
            S_DRAIN: begin
                route_busy_d = 1'b1;
            end
            S_ERROR: begin
                route_error_d = 1'b1;
                // Code is captured on entry and held while in ERROR.
                error_code_d  = (state_q == S_ERROR) ? error_code_q : err_cause;
            end
            default: begin
                async_enable_d = 1'b0;
            end
        endcase
    end

    assign async_enable = async_enable_q;
    assign route_active = route_active_q;
    assign route_busy   = route_busy_q;
    assign route_error  = route_error_q;
    assign error_code   = error_code_q;

endmodule

// File: tb/tb_clock_route_enable_sequencer.sv
// Scoreboard bench for clock_route_enable_sequencer. The stimulus process
// pushes the expected output vector and the cycle at which it should appear;
// the monitor pops and compares every time the DUT outputs change.
module tb_clock_route_enable_sequencer;

    logic       clock = 1'b0;
    logic       async_reset;
    logic       route_req;
    logic       error_clear;
    logic       async_enable;
    logic       async_enable_ack;
    logic       route_active;
    logic       route_busy;
    logic       route_error;
    logic [1:0] error_code;

    // Output vector: {async_enable, route_busy, route_active, route_error, error_code}
    localparam logic [5:0] V_IDLE  = 6'b000000;
    localparam logic [5:0] V_REQ   = 6'b110000;
    localparam logic [5:0] V_ACT   = 6'b101000;
    localparam logic [5:0] V_DRAIN = 6'b010000;
    localparam logic [5:0] V_ERR1  = 6'b000101;
    localparam logic [5:0] V_ERR2  = 6'b000110;
    localparam logic [5:0] V_ERR3  = 6'b000111;

    typedef struct {
        int         cyc;
        logic [5:0] vec;
    } exp_t;

    exp_t       sb_q[$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic [5:0] last_vec = 6'b0;

    clock_route_enable_sequencer dut (
        .clock            (clock),
        .async_reset      (async_reset),
        .route_req        (route_req),
        .error_clear      (error_clear),
        .async_enable     (async_enable),
        .async_enable_ack (async_enable_ack),
        .route_active     (route_active),
        .route_busy       (route_busy),
        .route_error      (route_error),
        .error_code       (error_code)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [5:0] out_vec();
        return {async_enable, route_busy, route_active, route_error, error_code};
    endfunction

    // Expect the outputs to become vec after n more rising edges.
    task automatic expect_out(input int n, input logic [5:0] vec);
        exp_t e;
        e.cyc = cyc + n;
        e.vec = vec;
        sb_q.push_back(e);
    endtask

    task automatic go(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b want %b at cyc %0d", name, act, req, cyc);
        end
    endtask

    // Monitor: every output change is matched against the scoreboard head.
    always @(negedge clock) begin
        logic [5:0] cur;
        exp_t       e;
        cur = out_vec();
        if (cur !== last_vec) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change: got %b at cyc %0d, nothing expected", cur, cyc);
            end else begin
                e = sb_q.pop_front();
                if (cur !== e.vec || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL out_change: got %b at cyc %0d want %b at cyc %0d",
                             cur, cyc, e.vec, e.cyc);
                end
            end
            last_vec = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        async_reset      = 1'b1;
        route_req        = 1'b0;
        error_clear      = 1'b0;
        async_enable_ack = 1'b0;
        go(3);
        check("reset_state", out_vec(), V_IDLE);
        async_reset = 1'b0;
        go(2);

        // Nominal bring-up: ack raised 3 cycles after async_enable.
        route_req = 1'b1;
        expect_out(1, V_REQ);
        go(4);
        async_enable_ack = 1'b1;
        expect_out(7, V_ACT);
        go(9);

        // Ack loss for one cycle while ACTIVE, then clear with ack low.
        async_enable_ack = 1'b0;
        expect_out(3, V_ERR3);
        go(1);
        async_enable_ack = 1'b1;
        go(3);
        async_enable_ack = 1'b0;
        route_req        = 1'b0;
        go(3);
        error_clear = 1'b1;
        expect_out(1, V_IDLE);
        go(1);
        error_clear = 1'b0;
        go(2);

        // Abort during SETTLE cycle 2, then ack drops during DRAIN.
        route_req = 1'b1;
        expect_out(1, V_REQ);
        go(1);
        async_enable_ack = 1'b1;
        go(5);
        route_req = 1'b0;
        expect_out(1, V_DRAIN);
        go(4);
        async_enable_ack = 1'b0;
        expect_out(3, V_IDLE);
        go(5);

        // Drain timeout with the ack stuck high; clear rejected while ack high.
        route_req        = 1'b1;
        async_enable_ack = 1'b1;
        expect_out(1, V_REQ);
        expect_out(7, V_ACT);
        go(9);
        route_req = 1'b0;
        expect_out(1, V_DRAIN);
        expect_out(201, V_ERR2);
        go(203);
        error_clear = 1'b1;
        go(1);
        error_clear = 1'b0;
        check("clear_rejected_ack_high", out_vec(), V_ERR2);
        async_enable_ack = 1'b0;
        go(3);
        error_clear = 1'b1;
        expect_out(1, V_IDLE);
        go(1);
        error_clear = 1'b0;
        go(2);

        // Request timeout with ack held low.
        route_req = 1'b1;
        expect_out(1, V_REQ);
        expect_out(201, V_ERR1);
        go(202);
        check("req_timeout_enable_low", {5'b0, async_enable}, 6'b0);
        route_req   = 1'b0;
        error_clear = 1'b1;
        expect_out(1, V_IDLE);
        go(1);
        error_clear = 1'b0;
        go(2);

        // Reset at REQ cycle 10: outputs clear without a clock edge.
        route_req = 1'b1;
        expect_out(1, V_REQ);
        go(11);
        #2;
        expect_out(1, V_IDLE);
        async_reset = 1'b1;
        #1;
        check("async_reset_immediate", out_vec(), V_IDLE);
        go(2);
        async_reset = 1'b0;
        expect_out(1, V_REQ);
        go(3);
        route_req = 1'b0;
        expect_out(1, V_DRAIN);
        expect_out(2, V_IDLE);
        go(5);

        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_change: want %b at cyc %0d, never seen", e.vec, e.cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
